// File: rtl/alu_pipe.sv
// alu_pipe: registered RV32I-style ALU with a valid/ready handshake on both
// sides and an optional shift-and-add multiplier that holds off new requests
// while it iterates. Result, zero and illegal flags share one output register.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW   = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One output beat: result plus its flags, always written together.
  typedef struct packed {
    logic [WIDTH-1:0] rd;
    logic             zero;
    logic             illegal;
  } res_t;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;

  res_t             out_q;
  logic             out_valid_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_d;
  logic             ill_d;
  logic             is_mul;
  logic             in_fire;
  res_t             alu_res;
  res_t             mul_res;

  assign shamt   = rs2[SHW-1:0];
  assign is_mul  = MUL_EN && (alu_sel == OP_MUL);

  // A new op may enter only when the FSM is idle and the output slot is free
  // or emptying this cycle, so a finished result never overwrites a live one.
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  // Single-cycle datapath; MUL falls through to zero here and is handled by the FSM.
  always_comb begin
    alu_d = '0;
    ill_d = 1'b0;
    case (alu_sel)
      OP_ADD:  alu_d = rs1 + rs2;
      OP_SUB:  alu_d = rs1 + ~rs2 + WIDTH'(1);
      OP_SLL:  alu_d = rs1 << shamt;
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
      OP_XOR:  alu_d = rs1 ^ rs2;
      OP_SRL:  alu_d = rs1 >> shamt;
      OP_SRA:  alu_d = $unsigned($signed(rs1) >>> shamt);
      OP_OR:   alu_d = rs1 | rs2;
      OP_AND:  alu_d = rs1 & rs2;
      OP_MUL:  ill_d = ~MUL_EN;
      default: ill_d = 1'b1;
    endcase
  end

  assign alu_res = '{rd: alu_d, zero: (alu_d == '0), illegal: ill_d};
  assign mul_res = '{rd: acc_q, zero: (acc_q == '0), illegal: 1'b0};

  // Control FSM and shift-and-add multiplier: one multiplier bit per cycle,
  // WIDTH iterations, then a DONE cycle that hands the product to the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_fire && is_mul) begin
            mcand_q  <= rs1;
            mplier_q <= rs2;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output register: load on a single-cycle accept or MUL completion, clear on
  // drain. Load wins over drain so accept+drain in one cycle leaves no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (in_fire && !is_mul) begin
      out_q       <= alu_res;
      out_valid_q <= 1'b1;
    end else if (state_q == S_DONE) begin
      out_q       <= mul_res;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign rd        = out_q.rd;
  assign zero      = out_q.zero;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, hand-written multi-cycle
// sequences (MUL latency, streaming, backpressure, reset abort) and a
// randomized run scored against a plain-arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  rs1 = '0;
  logic [W-1:0]  rs2 = '0;
  logic [3:0]    alu_sel = '0;

  logic          in_ready, out_valid, zero, illegal;
  logic [W-1:0]  rd;
  logic          in_ready0, out_valid0, zero0, illegal0;
  logic [W-1:0]  rd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .alu_sel(alu_sel), .out_valid(out_valid),
    .out_ready(out_ready), .rd(rd), .zero(zero), .illegal(illegal));

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .rs1(rs1), .rs2(rs2), .alu_sel(alu_sel), .out_valid(out_valid0),
    .out_ready(out_ready), .rd(rd0), .zero(zero0), .illegal(illegal0));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic        z;
    logic        ill;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {rd, zero, illegal} straight from the op definitions.
  function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input bit mul_en);
    logic [31:0] r;
    logic        ill;
    logic [63:0] p;
    int unsigned sh;
    sh  = b % 32;
    ill = 1'b0;
    r   = '0;
    case (op)
      4'd0:  r = a + b;
      4'd8:  r = a - b;
      4'd1:  r = a << sh;
      4'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd5:  r = a >> sh;
      4'd13: r = $unsigned($signed(a) >>> sh);
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd9: begin
        if (mul_en) begin
          p = 64'(a) * 64'(b);
          r = p[31:0];
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    return {r, (r == 32'd0), ill};
  endfunction

  // One op with the output free; result must show up after one edge.
  task automatic apply_vec(input vec_t v, input string name);
    @(negedge clk);
    in_valid  = 1'b1;
    alu_sel   = v.op;
    rs1       = v.a;
    rs2       = v.b;
    out_ready = 1'b1;
    #1 check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_res"}, 64'({out_valid, rd, zero, illegal}), 64'({1'b1, v.rd, v.z, v.ill}));
  endtask

  logic [31:0] s_a[4], s_b[4], s_exp[4];
  logic [3:0]  s_op[4];
  logic [33:0] q[$];
  logic [33:0] held;
  logic [33:0] exp_r;
  logic        stall;
  int          lat, busy;
  bit          seen;

  initial begin
    vecs[0]  = '{4'b0000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0};
    vecs[1]  = '{4'b1000, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2]  = '{4'b1101, 32'h8000_0000, 32'd36,        32'hF800_0000, 1'b0, 1'b0};
    vecs[3]  = '{4'b0101, 32'h8000_0000, 32'd36,        32'h0800_0000, 1'b0, 1'b0};
    vecs[4]  = '{4'b0001, 32'h1,         32'd36,        32'h10,        1'b0, 1'b0};
    vecs[5]  = '{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0};
    vecs[6]  = '{4'b0011, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0};
    vecs[7]  = '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0110, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
    vecs[9]  = '{4'b0111, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 1'b0, 1'b0};
    vecs[10] = '{4'b1111, 32'h1,         32'h2,         32'h0,         1'b1, 1'b1};
    vecs[11] = '{4'b1010, 32'h5,         32'h6,         32'h0,         1'b1, 1'b1};
    vecs[12] = '{4'b1101, 32'h7FFF_FFFF, 32'd31,        32'h0,         1'b1, 1'b0};
    vecs[13] = '{4'b0010, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0};
    vecs[14] = '{4'b0001, 32'h1,         32'hFFFF_FFE1, 32'h2,         1'b0, 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_state", 64'({out_valid, rd, zero, illegal}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed vector table
    for (int i = 0; i < 15; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // MUL latency and busy window; MUL_EN=0 instance must flag it as illegal
    @(negedge clk);
    in_valid  = 1'b1;
    alu_sel   = 4'b1001;
    rs1       = 32'h0001_0001;
    rs2       = 32'h0001_0001;
    out_ready = 1'b1;
    #1 check("mul_accept", 64'({in_ready, in_ready0}), 64'b11);
    @(negedge clk);
    in_valid = 1'b0;
    check("nomul_res", 64'({out_valid0, rd0, zero0, illegal0}), 64'({1'b1, 32'h0, 1'b1, 1'b1}));
    lat  = 0;
    busy = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      lat++;
      @(negedge clk);
    end
    check("mul_latency", 64'(lat), 64'd33);
    check("mul_busy", 64'(busy), 64'd33);
    check("mul_res", 64'({out_valid, rd, zero, illegal}), 64'({1'b1, 32'h0002_0001, 1'b0, 1'b0}));
    check("mul_ready_after", 64'(in_ready), 64'd1);

    // Streaming: four ops on four consecutive cycles
    s_op[0] = 4'b0000; s_a[0] = 32'd3;  s_b[0] = 32'd4;  s_exp[0] = 32'd7;
    s_op[1] = 4'b0110; s_a[1] = 32'hF0; s_b[1] = 32'h0F; s_exp[1] = 32'hFF;
    s_op[2] = 4'b0111; s_a[2] = 32'hFF; s_b[2] = 32'h3C; s_exp[2] = 32'h3C;
    s_op[3] = 4'b0100; s_a[3] = 32'hFF; s_b[3] = 32'h0F; s_exp[3] = 32'hF0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      alu_sel  = s_op[i];
      rs1      = s_a[i];
      rs2      = s_b[i];
      #1 check($sformatf("stream%0d_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      check($sformatf("stream%0d_res", i), 64'({out_valid, rd}), 64'({1'b1, s_exp[i]}));
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: hold the consumer off for 3 cycles, then accept on release
    in_valid  = 1'b1;
    alu_sel   = 4'b0000;
    rs1       = 32'd10;
    rs2       = 32'd20;
    out_ready = 1'b0;
    #1 check("bp_first_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    alu_sel = 4'b1000;
    rs1     = 32'd100;
    rs2     = 32'd1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("bp_stall%0d", i), 64'({in_ready, out_valid, rd}), 64'({1'b0, 1'b1, 32'd30}));
      @(negedge clk);
    end
    check("bp_hold", 64'({out_valid, rd}), 64'({1'b1, 32'd30}));
    out_ready = 1'b1;
    #1 check("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_res", 64'({out_valid, rd}), 64'({1'b1, 32'd99}));
    @(negedge clk);

    // Reset 10 cycles into a MUL: no result, idle afterwards
    in_valid  = 1'b1;
    alu_sel   = 4'b1001;
    rs1       = 32'd3;
    rs2       = 32'd5;
    out_ready = 1'b1;
    #1 check("abort_accept", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort_in_reset", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    apply_vec('{4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0}, "abort_add");
    @(negedge clk);

    // Randomized traffic against the reference model
    stall = 1'b0;
    held  = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!out_valid) check("rand_idle_flags", 64'({zero, illegal}), 64'd0);
      if (stall) check("rand_stall_hold", 64'({out_valid, rd, zero, illegal}), 64'({1'b1, held}));
      in_valid  = ($urandom_range(0, 9) < 7);
      alu_sel   = 4'($urandom_range(0, 15));
      rs1       = $urandom;
      rs2       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        check("rand_q_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_r = q.pop_front();
          check("rand_res", 64'({rd, zero, illegal}), 64'(exp_r));
        end
      end
      if (in_valid && in_ready) q.push_back(model(alu_sel, rs1, rs2, 1'b1));
      stall = out_valid && !out_ready;
      held  = {rd, zero, illegal};
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && q.size() != 0; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        exp_r = q.pop_front();
        check("drain_res", 64'({rd, zero, illegal}), 64'(exp_r));
      end
    end
    check("rand_drain_empty", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered ALU for the pipelined RISC-V core; successor to the combinational 3-op execute ALU.
- Width is generic. Full RV32I ALU op set plus an optional iterative multiplier.
- valid/ready handshake on input and output, so the execute stage can stall on multi-cycle ops.
- Registered result with zero and illegal-op flags.

Parameters:
- WIDTH, 32, datapath width; power of two, >= 8.
- MUL_EN, 1, 1 = MUL op implemented; 0 = MUL code treated as illegal.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block accepts request this cycle.
- rs1  in  WIDTH  operand A.
- rs2  in  WIDTH  operand B.
- alu_sel  in  4  op code: bit3 = funct7[5], bits2:0 = funct3.
- out_valid  out  1  rd/zero/illegal valid.
- out_ready  in  1  consumer takes result.
- rd  out  WIDTH  result.
- zero  out  1  rd == 0.
- illegal  out  1  op code unsupported.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low.
  - Reset asserted: rd = 0, zero = 0, illegal = 0, out_valid = 0, FSM = IDLE, mul counter = 0.
  - in_ready = 1 immediately after reset deassertion.
- Op codes (alu_sel):
  - 0000 ADD
  - 1000 SUB (rs1 + ~rs2 + 1)
  - 0001 SLL
  - 0010 SLT (signed)
  - 0011 SLTU
  - 0100 XOR
  - 0101 SRL
  - 1101 SRA
  - 0110 OR
  - 0111 AND
  - 1001 MUL (low WIDTH bits of rs1*rs2, unsigned)
  - All other codes, and 1001 when MUL_EN = 0: rd = 0, illegal = 1.
- Arithmetic rules:
  - Add/sub wrap modulo 2^WIDTH.
  - Shift amount = rs2[log2(WIDTH)-1:0]; upper bits ignored.
  - SLT/SLTU produce 0 or 1, zero-extended.
- Handshake:
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - in_ready = (FSM == IDLE) && (!out_valid || out_ready); combinational, no dependency on in_valid.
  - rd, zero and illegal are stable while out_valid && !out_ready.
- Single-cycle ops:
  - Result registered on the accepting edge; out_valid = 1 the next cycle (latency 1).
  - Back-to-back throughput is 1/cycle while out_ready = 1.
- FSM:
  - IDLE: accept a single-cycle op -> stay in IDLE. Accept MUL -> MUL.
    - On MUL accept: latch multiplicand = rs1, multiplier = rs2, acc = 0, cnt = 0.
  - MUL: each cycle, if multiplier[0] then acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, cnt++.
    - After WIDTH iterations -> DONE.
    - in_ready = 0 throughout.
  - DONE: load rd = acc, out_valid = 1, zero/illegal updated -> IDLE.
    - MUL total latency = WIDTH + 1 cycles from accept to out_valid (33 at WIDTH = 32).
- Output register is guaranteed empty when DONE writes: MUL is accepted only if the output is free or draining that cycle.
- Simultaneous out-drain and in-accept in the same cycle: the old result leaves and the new result replaces it on the next edge, with no bubble.
- rst_n asserted mid-MUL:
  - Operation discarded and no result produced.
  - After release, FSM = IDLE and in_ready = 1.
- zero and illegal are registered with rd; both are 0 whenever out_valid = 0.

Test Plan:
- ADD rs1 = 0xFFFFFFFF, rs2 = 1 -> next cycle rd = 0, zero = 1, out_valid = 1. SUB 5 - 7 -> rd = 0xFFFFFFFE, zero = 0.
- Shifts with rs1 = 0x80000000, rs2 = 36 (shamt 4):
  - SRA -> 0xF8000000
  - SRL -> 0x08000000
  - SLL with rs1 = 1 -> 0x10
- SLT/SLTU with rs1 = 0xFFFFFFFF, rs2 = 1 -> SLT rd = 1, SLTU rd = 0.
- MUL 0x00010001 * 0x00010001:
  - in_ready = 0 for 33 cycles after accept.
  - out_valid = 1 on cycle 33 with rd = 0x00020001.
  - Repeat with MUL_EN = 0 -> latency 1, rd = 0, illegal = 1.
- Backpressure and streaming:
  - Stream ADD, OR, AND, XOR with out_ready = 1 -> 4 results on 4 consecutive cycles.
  - Hold out_ready = 0 for 3 cycles -> rd stable and in_ready = 0; on release, the next op is accepted that same cycle.
- Illegal op and reset abort:
  - alu_sel = 1111 -> rd = 0, illegal = 1.
  - Assert rst_n low 10 cycles into a MUL -> out_valid stays 0, in_ready = 1 after release, and a following ADD 2 + 3 returns 5.
